instr_encoder: RTL and testbench

//  Packs RISC-V instruction fields (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm) into 32-bit instruction words.
//  It is the inverse of the decode/immediate-extraction path.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/instr_encoder_fifo.sv | 61 ++++++
 rtl/instr_encoder.sv | 111 +++++++++++
 tb/tb_instr_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding types: instruction format selector and base opcode constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_SB = 3'd3,
    FMT_U  = 3'd4,
    FMT_UJ = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  function automatic logic fmt_is_legal(input logic [2:0] f);
    return (f <= 3'(FMT_UJ));
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous output buffer for encoded words; head word reads as zero while empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q,  cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  // Flags come from registered state, so a pop never frees a slot for a push in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RISC-V fields into 32-bit words, buffers them and emits each with its byte address.
// Optional immediate range checking is enabled by defining ENC_IMM_CHECK_EN.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        addr_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  logic [31:0] enc_word;
  logic        fmt_ok;
  logic        imm_ok;
  logic        accept, push, pop;
  logic        fifo_full, fifo_empty;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  always_comb begin
    enc_word = '0;
    fmt_ok   = fmt_is_legal(fmt);
    case (fmt)
      FMT_R:   enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB:  enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   enc_word = {imm[31:12], rd, opcode};
      FMT_UJ:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_word = '0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = imm;

  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: imm_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      FMT_SB:       imm_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
      FMT_UJ:       imm_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
      FMT_U:        imm_ok = (imm[11:0] == 12'h000);
      default:      imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  // A rejected bundle still completes its handshake; it is simply not queued.
  assign accept = in_valid && in_ready;
  assign push   = accept && fmt_ok && imm_ok;
  assign err_d  = accept && !(fmt_ok && imm_ok);
  assign pop    = out_valid && out_ready;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (enc_word),
    .pop_i   (pop),
    .rdata_o (out_instr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;

  always_comb begin
    addr_d = addr_q;
    if (addr_clr)  addr_d = BASE_ADDR;
    else if (pop)  addr_d = addr_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign out_addr = addr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        addr_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder #(
    .FIFO_DEPTH (4),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .addr_clr  (addr_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    in_valid = 1'b1;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr",  out_addr,  BASE);
    chk("rst_err",       32'(err),  32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // addi x1,x0,5
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", out_instr, 32'h0050_0093);
    chk("addi_addr",  out_addr,  BASE);
    in_valid = 1'b0;
    step();
    chk("addi_popped", 32'(out_valid), 32'd0);
    chk("addi_next_addr", out_addr, BASE + 32'd4);

    // add x3,x1,x2 then sw x2,8(x1) back to back
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step();
    chk("add_instr", out_instr, 32'h0020_81B3);
    chk("add_addr",  out_addr,  BASE + 32'd4);
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    step();
    chk("sw_instr", out_instr, 32'h0020_A423);
    chk("sw_addr",  out_addr,  BASE + 32'd8);

    // beq x0,x0,-4 ; jal x1,8 ; lui x5,0x12345
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    step();
    chk("beq_instr", out_instr, 32'hFE00_0EE3);
    chk("beq_addr",  out_addr,  BASE + 32'd12);
    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    step();
    chk("jal_instr", out_instr, 32'h0080_00EF);
    chk("jal_addr",  out_addr,  BASE + 32'd16);
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    step();
    chk("lui_instr", out_instr, 32'h1234_52B7);
    chk("lui_addr",  out_addr,  BASE + 32'd20);
    in_valid = 1'b0;
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Fill to full with consumer stalled
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
      step();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head",     out_instr, 32'h0010_0093);
    chk("full_addr",     out_addr,  BASE + 32'd24);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    chk("stall_head", out_instr, 32'h0010_0093);
    chk("stall_addr", out_addr,  BASE + 32'd24);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    // Release while still offering word 5: no pass-through on the full cycle
    out_ready = 1'b1;
    step();
    chk("drain1_head", out_instr, 32'h0020_0093);
    chk("drain1_addr", out_addr,  BASE + 32'd28);
    chk("drain1_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("drain2_head", out_instr, 32'h0030_0093);
    chk("drain2_addr", out_addr,  BASE + 32'd32);
    step();
    chk("drain3_head", out_instr, 32'h0040_0093);
    chk("drain3_addr", out_addr,  BASE + 32'd36);
    step();
    chk("drain4_head", out_instr, 32'h0050_0093);
    chk("drain4_addr", out_addr,  BASE + 32'd40);
    step();
    chk("drain_done", 32'(out_valid), 32'd0);

    // Illegal fmt with one word queued
    out_ready = 1'b0;
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step();
    drive(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    in_valid = 1'b0;
    chk("illegal_err",  32'(err), 32'd1);
    chk("illegal_head", out_instr, 32'h0020_81B3);
    chk("illegal_ready", 32'(in_ready), 32'd1);
    step();
    chk("illegal_err_clear", 32'(err), 32'd0);
    chk("illegal_still_one", out_instr, 32'h0020_81B3);
    out_ready = 1'b1;
    step();
    chk("illegal_drained", 32'(out_valid), 32'd0);
    chk("illegal_addr", out_addr, BASE + 32'd48);

    // I-type immediate 2048 (out of range when checking is enabled)
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    in_valid = 1'b0;
`ifdef ENC_IMM_CHECK_EN
    chk("imm2048_err",   32'(err), 32'd1);
    chk("imm2048_drop",  32'(out_valid), 32'd0);
`else
    chk("imm2048_err",   32'(err), 32'd0);
    chk("imm2048_instr", out_instr, 32'h8000_0093);
    chk("imm2048_addr",  out_addr,  BASE + 32'd48);
`endif
    step();
    chk("imm2048_after", 32'(out_valid), 32'd0);

    // Async reset with two words queued
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_instr", out_instr, 32'h0);
    chk("midrst_addr",  out_addr,  BASE);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;

    // Advance the address once, then clear it during a pop
    out_ready = 1'b1;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    in_valid = 1'b0;
    step();
    chk("clr_pre_addr", out_addr, BASE + 32'd4);
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    step();
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
    chk("clr_head", out_instr, 32'h0070_0093);
    chk("clr_addr", out_addr,  BASE);
    step();
    chk("clr_next_addr", out_addr, BASE + 32'd4);
    chk("clr_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
